word_serializer_param: RTL and testbench



---
 rtl/word_serializer_param_pkg.sv | 21 ++
 rtl/word_serializer_param.sv | 147 ++++++++++++++
 tb/tb_word_serializer_param.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/word_serializer_param_pkg.sv
// Shared types and helpers for the parametrised word serializer.
package ser_pkg;

  typedef enum logic [0:0] {
    SER_IDLE  = 1'b0,
    SER_SHIFT = 1'b1
  } ser_state_e;

  localparam int SER_IN_W_DEF  = 32;
  localparam int SER_OUT_W_DEF = 8;

  // Lane counter width; a single-lane word still needs a 1-bit counter.
  function automatic int ser_cnt_w(input int ratio);
    if (ratio <= 1) begin
      return 1;
    end else begin
      return $clog2(ratio);
    end
  endfunction

endpackage

// File: rtl/word_serializer_param.sv
// Serializes IN_W-bit words into IN_W/OUT_W lanes with valid/ready on both sides.
// Optional macro SERIALIZER_PARITY_EN adds parity_out (XOR of data_out).
module word_serializer_param
  import ser_pkg::*;
#(
  parameter int IN_W      = SER_IN_W_DEF,
  parameter int OUT_W     = SER_OUT_W_DEF,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk_4f,
  input  logic             reset,
  input  logic             valid_in,
  output logic             ready_in,
  input  logic [IN_W-1:0]  data_in,
  output logic             valid_out,
  input  logic             ready_out,
  output logic [OUT_W-1:0] data_out,
  output logic             last_out,
`ifdef SERIALIZER_PARITY_EN
  output logic             parity_out,
`endif
  output logic             busy
);

  localparam int RATIO = IN_W / OUT_W;
  localparam int CNT_W = ser_cnt_w(RATIO);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RATIO - 1);

  if (((IN_W % OUT_W) != 0) || (IN_W < OUT_W)) begin : g_bad_width
    $error("word_serializer_param: IN_W must be a positive multiple of OUT_W");
  end

  ser_state_e       state_r;
  ser_state_e       next_state_s;
  logic [IN_W-1:0]  hold_r;
  logic [IN_W-1:0]  next_hold_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] next_cnt_s;
  logic             valid_r;
  logic [OUT_W-1:0] data_r;
  logic             last_r;
  logic [OUT_W-1:0] next_lane_s;
  logic             next_shift_s;

  function automatic logic [OUT_W-1:0] lane_of(input logic [IN_W-1:0] w,
                                               input logic [CNT_W-1:0] c);
    logic [CNT_W-1:0] idx;
    idx = (MSB_FIRST != 0) ? (LAST_CNT - c) : c;
    return w[int'(idx) * OUT_W +: OUT_W];
  endfunction

  function automatic logic parity_of(input logic [OUT_W-1:0] d);
    return ^d;
  endfunction

  assign busy      = (state_r == SER_SHIFT);
  assign ready_in  = !busy || (last_r && ready_out);
  assign valid_out = valid_r;
  assign data_out  = data_r;
  assign last_out  = last_r;

  // Next state, holding word and lane index from the two handshakes.
  always_comb begin
    next_state_s = state_r;
    next_hold_s  = hold_r;
    next_cnt_s   = cnt_r;
    case (state_r)
      SER_IDLE: begin
        if (valid_in) begin
          next_state_s = SER_SHIFT;
          next_hold_s  = data_in;
          next_cnt_s   = {CNT_W{1'b0}};
        end else begin
          next_state_s = SER_IDLE;
        end
      end
      SER_SHIFT: begin
        if (ready_out) begin
          if (last_r) begin
            next_cnt_s = {CNT_W{1'b0}};
            if (valid_in) begin
              next_hold_s = data_in;
            end else begin
              next_state_s = SER_IDLE;
            end
          end else begin
            next_cnt_s = cnt_r + CNT_W'(1);
          end
        end else begin
          next_cnt_s = cnt_r;
        end
      end
      default: begin
        next_state_s = SER_IDLE;
        next_cnt_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // Lane presented after the coming edge, so the outputs can be registered.
  always_comb begin
    next_shift_s = (next_state_s == SER_SHIFT);
    if (next_shift_s) begin
      next_lane_s = lane_of(next_hold_s, next_cnt_s);
    end else begin
      next_lane_s = {OUT_W{1'b0}};
    end
  end

  // State, holding register, counter and registered lane outputs.
  always_ff @(posedge clk_4f) begin
    if (reset) begin
      state_r <= SER_IDLE;
      hold_r  <= {IN_W{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
      valid_r <= 1'b0;
      data_r  <= {OUT_W{1'b0}};
      last_r  <= 1'b0;
    end else begin
      state_r <= next_state_s;
      hold_r  <= next_hold_s;
      cnt_r   <= next_cnt_s;
      valid_r <= next_shift_s;
      data_r  <= next_lane_s;
      last_r  <= next_shift_s && (next_cnt_s == LAST_CNT);
    end
  end

`ifdef SERIALIZER_PARITY_EN
  logic parity_r;

  assign parity_out = parity_r;

  // Parity follows the registered lane, zero while no lane is valid.
  always_ff @(posedge clk_4f) begin
    if (reset) begin
      parity_r <= 1'b0;
    end else begin
      parity_r <= parity_of(next_lane_s);
    end
  end
`else
  logic unused_parity_s;
  assign unused_parity_s = parity_of(next_lane_s);
`endif

endmodule

// File: tb/tb_word_serializer_param.sv
// Scoreboard bench: MSB-first and LSB-first 32->8 instances plus a 16->16 instance.
module tb_word_serializer_param;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } lane_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_ab, ready_ab;
  logic [31:0] data_ab;
  logic        valid_c, ready_c;
  logic [15:0] data_c;

  logic        ready_in_a, valid_a, last_a, busy_a, par_a;
  logic [7:0]  data_a;
  logic        ready_in_b, valid_b, last_b, busy_b, par_b;
  logic [7:0]  data_b;
  logic        ready_in_c, valid_out_c, last_c, busy_c, par_c;
  logic [15:0] data_out_c;

  lane_t       q[3][$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [7:0]  stall_lane = 8'h00;
  int          stall_left = 0;

  always #5 clk = ~clk;

  word_serializer_param #(.IN_W(32), .OUT_W(8), .MSB_FIRST(1)) u_msb (
    .clk_4f(clk), .reset(reset), .valid_in(valid_ab), .ready_in(ready_in_a),
    .data_in(data_ab), .valid_out(valid_a), .ready_out(ready_ab),
    .data_out(data_a), .last_out(last_a),
`ifdef SERIALIZER_PARITY_EN
    .parity_out(par_a),
`endif
    .busy(busy_a)
  );

  word_serializer_param #(.IN_W(32), .OUT_W(8), .MSB_FIRST(0)) u_lsb (
    .clk_4f(clk), .reset(reset), .valid_in(valid_ab), .ready_in(ready_in_b),
    .data_in(data_ab), .valid_out(valid_b), .ready_out(ready_ab),
    .data_out(data_b), .last_out(last_b),
`ifdef SERIALIZER_PARITY_EN
    .parity_out(par_b),
`endif
    .busy(busy_b)
  );

  word_serializer_param #(.IN_W(16), .OUT_W(16), .MSB_FIRST(1)) u_one (
    .clk_4f(clk), .reset(reset), .valid_in(valid_c), .ready_in(ready_in_c),
    .data_in(data_c), .valid_out(valid_out_c), .ready_out(ready_c),
    .data_out(data_out_c), .last_out(last_c),
`ifdef SERIALIZER_PARITY_EN
    .parity_out(par_c),
`endif
    .busy(busy_c)
  );

`ifndef SERIALIZER_PARITY_EN
  assign par_a = 1'b0;
  assign par_b = 1'b0;
  assign par_c = 1'b0;
`endif

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Compare one DUT against the head of its expected-lane queue.
  task automatic mon(input int d, input logic v, input logic [31:0] dat, input logic l,
                     input logic b, input logic ri, input logic ro, input logic p);
    lane_t f;
    logic  exp_v;
    exp_v = (q[d].size() != 0);
    if (exp_v) begin
      f = q[d][0];
    end else begin
      f.data = 32'h0;
      f.last = 1'b0;
    end
    check_eq($sformatf("valid_out[%0d]", d), {31'h0, v}, {31'h0, exp_v});
    check_eq($sformatf("data_out[%0d]", d), dat, f.data);
    check_eq($sformatf("last_out[%0d]", d), {31'h0, l}, {31'h0, f.last});
    check_eq($sformatf("busy[%0d]", d), {31'h0, b}, {31'h0, exp_v});
    check_eq($sformatf("ready_in[%0d]", d), {31'h0, ri}, {31'h0, (!exp_v || (f.last && ro))});
`ifdef SERIALIZER_PARITY_EN
    check_eq($sformatf("parity_out[%0d]", d), {31'h0, p}, {31'h0, ^f.data});
`else
    if (p !== 1'b0) check_eq($sformatf("parity_tie[%0d]", d), {31'h0, p}, 32'h0);
`endif
    if (exp_v && ro) void'(q[d].pop_front());
  endtask

  // Backpressure generator and per-cycle monitor, away from the rising edge.
  always @(negedge clk) begin
    if (valid_a && data_a == stall_lane && stall_left > 0) begin
      ready_ab = 1'b0;
      stall_left--;
    end else begin
      ready_ab = 1'b1;
    end
    #1;
    mon(0, valid_a, {24'h0, data_a}, last_a, busy_a, ready_in_a, ready_ab, par_a);
    mon(1, valid_b, {24'h0, data_b}, last_b, busy_b, ready_in_b, ready_ab, par_b);
    mon(2, valid_out_c, {16'h0, data_out_c}, last_c, busy_c, ready_in_c, ready_c, par_c);
  end

  task automatic send(input int d, input logic [31:0] w);
    bit    done;
    lane_t e;
    done = 1'b0;
    for (int t = 0; t < 20 && !done; t++) begin
      @(negedge clk);
      if (d == 2) begin
        valid_c = 1'b1;
        data_c  = w[15:0];
      end else begin
        valid_ab = 1'b1;
        data_ab  = w;
      end
      #2;
      if ((d == 2) ? ready_in_c : ready_in_a) begin
        done = 1'b1;
        if (d == 2) begin
          e.data = {16'h0, w[15:0]};
          e.last = 1'b1;
          q[2].push_back(e);
        end else begin
          for (int i = 0; i < 4; i++) begin
            e.last = (i == 3);
            e.data = {24'h0, w[31-8*i -: 8]};
            q[0].push_back(e);
            e.data = {24'h0, w[8*i +: 8]};
            q[1].push_back(e);
          end
        end
      end
    end
    if (!done) check_eq("send_timeout", 32'h0, 32'h1);
  endtask

  task automatic idle_inputs();
    @(negedge clk);
    valid_ab = 1'b0;
    valid_c  = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      #3;
      if (q[0].size() == 0 && q[1].size() == 0 && q[2].size() == 0) break;
    end
    check_eq("drain", q[0].size() + q[1].size() + q[2].size(), 32'h0);
  endtask

  initial begin
    bit hit;
    reset    = 1'b1;
    valid_ab = 1'b0;
    data_ab  = 32'h0;
    valid_c  = 1'b0;
    data_c   = 16'h0;
    ready_ab = 1'b1;
    ready_c  = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Single word, both lane orders.
    send(0, 32'hAABBCCDD);
    idle_inputs();
    drain();

    // Back-to-back words with valid_in held high.
    send(0, 32'h01020304);
    send(0, 32'h05060708);
    idle_inputs();
    drain();

    // Three cycles of backpressure on lane BB.
    stall_lane = 8'hBB;
    stall_left = 3;
    send(0, 32'hAABBCCDD);
    idle_inputs();
    drain();
    check_eq("stall_used", stall_left, 32'h0);

    // Reset while lane CC is presented.
    send(0, 32'hAABBCCDD);
    idle_inputs();
    hit = 1'b0;
    for (int t = 0; t < 10 && !hit; t++) begin
      @(negedge clk);
      #2;
      if (valid_a && data_a == 8'hCC) begin
        hit   = 1'b1;
        reset = 1'b1;
        q[0].delete();
        q[1].delete();
      end
    end
    check_eq("reset_hit", {31'h0, hit}, 32'h1);
    @(negedge clk);
    reset = 1'b0;
    send(0, 32'h11223344);
    idle_inputs();
    drain();

    // Single-lane instance, back-to-back.
    send(2, 32'h0000_0001);
    send(2, 32'h0000_0003);
    idle_inputs();
    drain();

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
